// File: rtl/usr_burst_shifter_pkg.sv
// usr_pkg: shared types for the burst shift register.
//   mode_e  - 3-bit command encoding (modes 0-3 match the older 8-bit register)
//   state_e - control FSM states
//   is_shift_mode() - true for modes that run a multi-step burst
// Optional feature macro: USR_ROTATE_EN (ROL/ROR become burst shift modes).
package usr_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_LOAD  = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ASR   = 3'b100,
    MODE_ROL   = 3'b101,
    MODE_ROR   = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_shift_mode(input mode_e m);
    logic r;
    case (m)
      MODE_SHL, MODE_SHR, MODE_ASR: r = 1'b1;
`ifdef USR_ROTATE_EN
      MODE_ROL, MODE_ROR:           r = 1'b1;
`endif
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/usr_shift_step.sv
// usr_shift_step: combinational one-step datapath of the burst shifter.
// Ports:
//   mode_i   - latched burst mode
//   q_i      - current register contents
//   s_in_l_i - serial fill for the LSB on SHL
//   s_in_r_i - serial fill for the MSB on SHR
//   q_nxt_o  - register contents after one step
// Optional feature macro: USR_ROTATE_EN (rotate datapath present only when defined).
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  mode_e            mode_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             s_in_l_i,
  input  logic             s_in_r_i,
  output logic [WIDTH-1:0] q_nxt_o
);

  always_comb begin
    q_nxt_o = q_i;
    case (mode_i)
      MODE_SHL: q_nxt_o = {q_i[WIDTH-2:0], s_in_l_i};
      MODE_SHR: q_nxt_o = {s_in_r_i, q_i[WIDTH-1:1]};
      MODE_ASR: q_nxt_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
      MODE_ROL: q_nxt_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_ROR: q_nxt_o = {q_i[0], q_i[WIDTH-1:1]};
`endif
      default:  q_nxt_o = q_i;
    endcase
  end

endmodule

// File: rtl/usr_burst_shifter.sv
// usr_burst_shifter: parametrised universal shift register with a command
// handshake and autonomous multi-cycle burst shifts.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous reset, active HIGH (name kept for pin compatibility)
//   ena        - global enable; 0 freezes all state and deasserts cmd_ready
//   cmd_valid  - command request;  cmd_ready - command can be accepted
//   cmd_mode   - operation (see usr_pkg::mode_e);  cmd_count - burst length
//   d          - parallel load data
//   s_in_l     - LSB fill on SHL;  s_in_r - MSB fill on SHR
//   q          - register contents;  s_out_l = q[MSB];  s_out_r = q[0]
//   busy       - burst in progress;  done - one-cycle completion pulse
// Optional feature macro: USR_ROTATE_EN (modes 101/110 rotate; otherwise HOLD).
module usr_burst_shifter
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] d,
  input  logic             s_in_l,
  input  logic             s_in_r,
  output logic [WIDTH-1:0] q,
  output logic             s_out_l,
  output logic             s_out_r,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  mode_e            mode_q,  mode_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic             done_q,  done_d;

  logic [WIDTH-1:0] step_q;
  mode_e            cmd_mode_e;
  logic             accept;

  assign cmd_mode_e = mode_e'(cmd_mode);
  assign cmd_ready  = (state_q == ST_IDLE) & ena;
  assign accept     = cmd_valid & cmd_ready;

  usr_shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode_i  (mode_q),
    .q_i     (q_q),
    .s_in_l_i(s_in_l),
    .s_in_r_i(s_in_r),
    .q_nxt_o (step_q)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      cnt_q   <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  // With ena low every register keeps its value, including a pending done,
  // so a paused burst resumes and still performs exactly the latched count.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    done_d  = done_q;
    if (ena) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_shift_mode(cmd_mode_e) && (cmd_count != '0)) begin
              // Latch the burst; q is untouched on the accepting edge.
              state_d = ST_RUN;
              mode_d  = cmd_mode_e;
              cnt_d   = cmd_count;
            end else begin
              case (cmd_mode_e)
                MODE_LOAD:  q_d = d;
                MODE_CLEAR: q_d = '0;
                default:    q_d = q_q;
              endcase
              done_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          q_d = step_q;
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign q       = q_q;
  assign s_out_l = q_q[WIDTH-1];
  assign s_out_r = q_q[0];
  assign busy    = (state_q == ST_RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_usr_burst_shifter.sv
module tb_usr_burst_shifter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_mode;
  logic [3:0] cmd_count;
  logic [7:0] d;
  logic       s_in_l;
  logic       s_in_r;
  logic [7:0] q;
  logic       s_out_l;
  logic       s_out_r;
  logic       busy;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [2:0] M_HOLD = 3'b000, M_SHL = 3'b001, M_LOAD = 3'b010,
                         M_SHR = 3'b011, M_ASR = 3'b100, M_ROL = 3'b101,
                         M_CLEAR = 3'b111;

  usr_burst_shifter #(.WIDTH(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_mode (cmd_mode),
    .cmd_count(cmd_count),
    .d        (d),
    .s_in_l   (s_in_l),
    .s_in_r   (s_in_r),
    .q        (q),
    .s_out_l  (s_out_l),
    .s_out_r  (s_out_r),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: through the rising edge, then to the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Check q, busy and done together.
  task automatic chk3(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    chk({tag, ".q"},    {24'd0, q},    {24'd0, eq});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, ed});
  endtask

  // Issue one command for exactly the next edge (edge k).
  task automatic issue(input logic [2:0] m, input logic [3:0] n, input logic [7:0] dv);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_count = n;
    d         = dv;
    step();
    cmd_valid = 1'b0;
    cmd_mode  = M_HOLD;
    cmd_count = 4'd0;
    d         = 8'h00;
  endtask

  initial begin
    rst_n = 1'b1; ena = 1'b1; cmd_valid = 1'b0; cmd_mode = M_HOLD;
    cmd_count = 4'd0; d = 8'h00; s_in_l = 1'b0; s_in_r = 1'b0;
    #1;
    chk3("reset", 8'h00, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    // LOAD
    issue(M_LOAD, 4'd0, 8'hA5);
    chk3("load_k", 8'hA5, 1'b0, 1'b1);
    step();
    chk3("load_k1", 8'hA5, 1'b0, 1'b0);

    // SHL x3 with LSB fill 1
    s_in_l = 1'b1;
    issue(M_SHL, 4'd3, 8'hFF);
    chk3("shl_k", 8'hA5, 1'b1, 1'b0);
    chk("shl_ready_busy", {31'd0, cmd_ready}, 32'd0);
    step(); chk3("shl_s1", 8'h4B, 1'b1, 1'b0);
    step(); chk3("shl_s2", 8'h97, 1'b1, 1'b0);
    step(); chk3("shl_s3", 8'h2F, 1'b0, 1'b1);
    s_in_l = 1'b0;
    // Back-to-back: accept a LOAD in the done cycle.
    issue(M_LOAD, 4'd0, 8'h80);
    chk3("b2b_load", 8'h80, 1'b0, 1'b1);

    // ASR x2 from 0x80
    issue(M_ASR, 4'd2, 8'h00);
    chk3("asr_k", 8'h80, 1'b1, 1'b0);
    step(); chk3("asr_s1", 8'hC0, 1'b1, 1'b0);
    step(); chk3("asr_s2", 8'hE0, 1'b0, 1'b1);

    // SHR x2 from 0x80, MSB fill 0
    issue(M_LOAD, 4'd0, 8'h80);
    s_in_r = 1'b0;
    issue(M_SHR, 4'd2, 8'h00);
    step(); chk3("shr_s1", 8'h40, 1'b1, 1'b0);
    step(); chk3("shr_s2", 8'h20, 1'b0, 1'b1);
    chk("s_out_l", {31'd0, s_out_l}, 32'd0);
    chk("s_out_r", {31'd0, s_out_r}, 32'd0);

    // SHR x4 from 0xF0 with a 2-cycle pause; cmd_valid held high throughout
    issue(M_LOAD, 4'd0, 8'hF0);
    chk("s_out_l_f0", {31'd0, s_out_l}, 32'd1);
    cmd_valid = 1'b1; cmd_mode = M_SHR; cmd_count = 4'd4;
    step(); chk3("pause_k", 8'hF0, 1'b1, 1'b0);
    step(); chk3("pause_s1", 8'h78, 1'b1, 1'b0);
    step(); chk3("pause_s2", 8'h3C, 1'b1, 1'b0);
    ena = 1'b0;
    chk("pause_ready", {31'd0, cmd_ready}, 32'd0);
    step(); chk3("pause_h1", 8'h3C, 1'b1, 1'b0);
    step(); chk3("pause_h2", 8'h3C, 1'b1, 1'b0);
    ena = 1'b1;
    step(); chk3("pause_s3", 8'h1E, 1'b1, 1'b0);
    step(); chk3("pause_s4", 8'h0F, 1'b0, 1'b1);
    chk("pause_ready_done", {31'd0, cmd_ready}, 32'd1);
    step(); chk3("second_k", 8'h0F, 1'b1, 1'b0);
    cmd_valid = 1'b0;
    step(); chk3("second_s1", 8'h07, 1'b1, 1'b0);
    step(); chk3("second_s2", 8'h03, 1'b1, 1'b0);
    step(); chk3("second_s3", 8'h01, 1'b1, 1'b0);
    step(); chk3("second_s4", 8'h00, 1'b0, 1'b1);

    // done holds while ena is low, clears on next enabled edge
    ena = 1'b0;
    step(); chk3("done_hold", 8'h00, 1'b0, 1'b1);
    ena = 1'b1;
    step(); chk3("done_clear", 8'h00, 1'b0, 1'b0);

    // ROL x1 from 0x81
    issue(M_LOAD, 4'd0, 8'h81);
    issue(M_ROL, 4'd1, 8'h00);
`ifdef USR_ROTATE_EN
    chk3("rol_k", 8'h81, 1'b1, 1'b0);
    step(); chk3("rol_s1", 8'h03, 1'b0, 1'b1);
`else
    chk3("rol_k", 8'h81, 1'b0, 1'b1);
    step(); chk3("rol_k1", 8'h81, 1'b0, 1'b0);
`endif

    // Shift with count 0 acts as single-cycle no-op
    issue(M_LOAD, 4'd0, 8'h5A);
    issue(M_SHL, 4'd0, 8'hFF);
    chk3("shl0_k", 8'h5A, 1'b0, 1'b1);
    issue(M_HOLD, 4'd5, 8'hFF);
    chk3("hold_k", 8'h5A, 1'b0, 1'b1);
    issue(M_CLEAR, 4'd3, 8'hFF);
    chk3("clear_k", 8'h00, 1'b0, 1'b1);

    // Asynchronous reset mid-burst
    issue(M_LOAD, 4'd0, 8'hFF);
    s_in_l = 1'b0;
    issue(M_SHL, 4'd5, 8'h00);
    step(); step();
    chk3("pre_rst", 8'hFC, 1'b1, 1'b0);
    #2 rst_n = 1'b1;
    #1;
    chk3("rst_mid", 8'h00, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    chk3("rst_after", 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
